// File: rtl/rvx_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave port among NUM_MASTERS requesters.
// Latches one transaction at a time, routes the slave response back and aborts on timeout.
module rvx_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS*32-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]    m_read_request,
  input  logic [NUM_MASTERS-1:0]    m_write_request,
  input  logic [NUM_MASTERS*32-1:0] m_write_data,
  input  logic [NUM_MASTERS*4-1:0]  m_write_strobe,
  output logic [31:0]               m_read_data,
  output logic [NUM_MASTERS-1:0]    m_read_response,
  output logic [NUM_MASTERS-1:0]    m_write_response,
  output logic [NUM_MASTERS-1:0]    m_error,
  output logic [31:0]               s_address,
  output logic                      s_read_request,
  output logic                      s_write_request,
  output logic [31:0]               s_write_data,
  output logic [3:0]                s_write_strobe,
  input  logic [31:0]               s_read_data,
  input  logic                      s_read_response,
  input  logic                      s_write_response
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_MASTERS-1:0] req;
  logic [31:0]            addr_arr [NUM_MASTERS];
  logic [31:0]            data_arr [NUM_MASTERS];
  logic [3:0]             strb_arr [NUM_MASTERS];
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic                   slave_hit;
  logic                   last_cycle;
  logic                   timed_out;

  assign req = m_read_request | m_write_request;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i] = m_address[i*32 +: 32];
      data_arr[i] = m_write_data[i*32 +: 32];
      strb_arr[i] = m_write_strobe[i*4 +: 4];
    end
  end

  // First requester at or after the pointer, wrapping modulo NUM_MASTERS.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A response of the wrong type never matches; a real response wins over the timeout.
  assign slave_hit  = (state == BUSY) &&
                      (s_write_request ? s_write_response : s_read_response);
  assign last_cycle = (state == BUSY) && (cnt == CNT_LAST);
  assign timed_out  = last_cycle && !slave_hit;

  always_comb begin
    m_read_response  = '0;
    m_write_response = '0;
    m_error          = '0;
    m_read_data      = '0;
    if (slave_hit || timed_out) begin
      if (s_write_request) begin
        m_write_response[grant] = 1'b1;
      end else begin
        m_read_response[grant] = 1'b1;
        m_read_data            = timed_out ? 32'hDEAD_BEEF : s_read_data;
      end
      m_error[grant] = timed_out;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      grant           <= '0;
      cnt             <= '0;
      s_address       <= '0;
      s_write_data    <= '0;
      s_write_strobe  <= '0;
      s_read_request  <= 1'b0;
      s_write_request <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant           <= winner;
            s_address       <= addr_arr[winner];
            s_write_data    <= data_arr[winner];
            s_write_strobe  <= strb_arr[winner];
            s_write_request <= m_write_request[winner];
            s_read_request  <= !m_write_request[winner];
            cnt             <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (slave_hit || last_cycle) begin
            s_read_request  <= 1'b0;
            s_write_request <= 1'b0;
            ptr             <= (grant == IDX_LAST) ? '0 : grant + 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Randomized self-checking bench for rvx_bus_arbiter; the bench plays both the
// masters and the slave and predicts grants from a round-robin pointer model.
module tb_rvx_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N*32-1:0]   m_address = '0;
  logic [N-1:0]      m_read_request = '0;
  logic [N-1:0]      m_write_request = '0;
  logic [N*32-1:0]   m_write_data = '0;
  logic [N*4-1:0]    m_write_strobe = '0;
  logic [31:0]       m_read_data;
  logic [N-1:0]      m_read_response;
  logic [N-1:0]      m_write_response;
  logic [N-1:0]      m_error;
  logic [31:0]       s_address;
  logic              s_read_request;
  logic              s_write_request;
  logic [31:0]       s_write_data;
  logic [3:0]        s_write_strobe;
  logic [31:0]       s_read_data = '0;
  logic              s_read_response = 1'b0;
  logic              s_write_response = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: pending transaction per master plus the round-robin pointer.
  int          ptr = 0;
  bit          want_rd [N];
  bit          want_wr [N];
  logic [31:0] p_addr  [N];
  logic [31:0] p_data  [N];
  logic [3:0]  p_strb  [N];

  rvx_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m_address(m_address), .m_read_request(m_read_request),
    .m_write_request(m_write_request), .m_write_data(m_write_data),
    .m_write_strobe(m_write_strobe), .m_read_data(m_read_data),
    .m_read_response(m_read_response), .m_write_response(m_write_response),
    .m_error(m_error), .s_address(s_address), .s_read_request(s_read_request),
    .s_write_request(s_write_request), .s_write_data(s_write_data),
    .s_write_strobe(s_write_strobe), .s_read_data(s_read_data),
    .s_read_response(s_read_response), .s_write_response(s_write_response)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      m_read_request[i]         = want_rd[i];
      m_write_request[i]        = want_wr[i];
      m_address[i*32 +: 32]     = p_addr[i];
      m_write_data[i*32 +: 32]  = p_data[i];
      m_write_strobe[i*4 +: 4]  = p_strb[i];
    end
  endtask

  task automatic arm(input int i, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    want_rd[i] = rd;
    want_wr[i] = wr;
    p_addr[i]  = a;
    p_data[i]  = d;
    p_strb[i]  = s;
  endtask

  task automatic arm_random(input int i);
    int kind;
    kind = $urandom_range(0, 2);
    arm(i, kind != 1, kind != 0, $urandom, $urandom, 4'($urandom));
  endtask

  // Runs one transaction starting in IDLE. resp_cycle is the BUSY cycle index
  // (0 = first cycle s_*_request is high) at which the slave answers; any value
  // >= TO keeps the slave silent. observed returns the master the DUT pulsed.
  task automatic serve(input int resp_cycle, input bit noise,
                       input logic [31:0] rdata, output int observed);
    int          w;
    bit          exp_wr, done, is_resp, is_to;
    logic [31:0] ea, ed, exp_rd;
    logic [3:0]  es;
    logic [N-1:0] oh, exp_rr, exp_wresp, exp_err;
    w = -1;
    observed = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (w < 0 && (want_rd[idx] || want_wr[idx])) w = idx;
    end
    if (w < 0) begin
      checks++; errors++;
      $display("FAIL serve_setup: no master has a pending request");
      return;
    end
    exp_wr = want_wr[w];
    ea = p_addr[w]; ed = p_data[w]; es = p_strb[w];
    oh = '0; oh[w] = 1'b1;
    drive_masters();
    #1;
    checks++;
    if ({s_read_request, s_write_request} !== 2'b00) begin
      errors++;
      $display("FAIL idle_before_grant: got rd/wr=%b%b want 00", s_read_request, s_write_request);
    end
    tick();
    done = 0;
    for (int c = 0; c < TO && !done; c++) begin
      s_read_response  = 1'b0;
      s_write_response = 1'b0;
      s_read_data      = $urandom;
      is_resp = (c == resp_cycle);
      is_to   = (c == TO - 1) && !is_resp;
      if (is_resp) begin
        if (exp_wr) s_write_response = 1'b1;
        else begin
          s_read_response = 1'b1;
          s_read_data     = rdata;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        if (exp_wr) s_read_response = 1'b1;
        else        s_write_response = 1'b1;
      end
      if (is_resp || is_to) begin
        want_rd[w] = 1'b0;
        want_wr[w] = 1'b0;
        drive_masters();
      end else begin
        for (int i = 0; i < N; i++) begin
          m_address[i*32 +: 32]    = $urandom;
          m_write_data[i*32 +: 32] = $urandom;
          m_write_strobe[i*4 +: 4] = 4'($urandom);
        end
      end
      #1;
      exp_rr    = (!exp_wr && (is_resp || is_to)) ? oh : '0;
      exp_wresp = ( exp_wr && (is_resp || is_to)) ? oh : '0;
      exp_err   = is_to ? oh : '0;
      exp_rd    = (!exp_wr && is_resp) ? rdata :
                  (!exp_wr && is_to)   ? 32'hDEADBEEF : 32'h0;
      checks++;
      if ({s_read_request, s_write_request} !== {!exp_wr, exp_wr} || s_address !== ea ||
          s_write_data !== ed || s_write_strobe !== es) begin
        errors++;
        $display("FAIL busy_payload c=%0d: got rd/wr=%b%b a=%h d=%h s=%b want rd/wr=%b%b a=%h d=%h s=%b",
                 c, s_read_request, s_write_request, s_address, s_write_data, s_write_strobe,
                 !exp_wr, exp_wr, ea, ed, es);
      end
      checks++;
      if (m_read_response !== exp_rr || m_write_response !== exp_wresp || m_error !== exp_err) begin
        errors++;
        $display("FAIL response c=%0d: got rr=%b wr=%b err=%b want rr=%b wr=%b err=%b",
                 c, m_read_response, m_write_response, m_error, exp_rr, exp_wresp, exp_err);
      end
      checks++;
      if (m_read_data !== exp_rd) begin
        errors++;
        $display("FAIL read_data c=%0d: got %h want %h", c, m_read_data, exp_rd);
      end
      if (is_resp || is_to) begin
        done = 1;
        for (int i = 0; i < N; i++)
          if (m_read_response[i] || m_write_response[i]) observed = i;
      end
      tick();
    end
    s_read_response  = 1'b0;
    s_write_response = 1'b0;
    drive_masters();
    checks++;
    if ({s_read_request, s_write_request} !== 2'b00) begin
      errors++;
      $display("FAIL release: got rd/wr=%b%b want 00", s_read_request, s_write_request);
    end
    ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arm(0, 1, 0, 32'h1111_0000, 32'h0, 4'h0);
    arm(1, 0, 1, 32'h2222_0000, 32'hFFFF_FFFF, 4'hF);
    drive_masters();
    s_read_response = 1'b1;
    tick(); tick();
    checks++;
    if ({s_read_request, s_write_request, s_address, s_write_data, s_write_strobe} !== '0 ||
        {m_read_response, m_write_response, m_error, m_read_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s=%b%b %h %h %b m=%b %b %b %h want all zero",
               s_read_request, s_write_request, s_address, s_write_data, s_write_strobe,
               m_read_response, m_write_response, m_error, m_read_data);
    end
    s_read_response = 1'b0;
    arm(0, 0, 0, '0, '0, '0);
    arm(1, 0, 0, '0, '0, '0);
    drive_masters();
    reset = 1'b0;
    ptr = 0;
    tick();
  endtask

  task automatic test_single_read();
    int obs;
    arm(0, 1, 0, 32'h8000_0004, 32'h0, 4'h0);
    serve(3, 0, 32'h1234_5678, obs);
    checks++;
    if (obs != 0) begin
      errors++;
      $display("FAIL single_read_master: got %0d want 0", obs);
    end
  endtask

  task automatic test_contention();
    int obs0, obs1;
    ptr = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    arm(0, 0, 1, 32'h10, 32'hAAAA_0001, 4'hF);
    arm(1, 0, 1, 32'h20, 32'hBBBB_0002, 4'h3);
    serve(1, 1, 32'h0, obs0);
    serve(2, 1, 32'h0, obs1);
    checks++;
    if (obs0 != 0 || obs1 != 1) begin
      errors++;
      $display("FAIL contention_order: got %0d,%0d want 0,1", obs0, obs1);
    end
  endtask

  task automatic test_fairness();
    int obs, prev;
    prev = -1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        if (!want_rd[i] && !want_wr[i]) arm_random(i);
      serve($urandom_range(0, 3), 1, $urandom, obs);
      checks++;
      if (obs < 0 || obs == prev) begin
        errors++;
        $display("FAIL fairness t=%0d: got master %0d after %0d", t, obs, prev);
      end
      prev = obs;
    end
    arm(0, 0, 0, '0, '0, '0);
    arm(1, 0, 0, '0, '0, '0);
  endtask

  task automatic test_read_write_same_master();
    int obs;
    arm(1, 1, 1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b0011);
    serve(4, 1, 32'h0, obs);
    checks++;
    if (obs != 1) begin
      errors++;
      $display("FAIL rw_same_master: got %0d want 1", obs);
    end
  endtask

  task automatic test_timeout();
    int obs;
    arm(1, 1, 0, 32'h0000_0100, 32'h0, 4'h0);
    serve(TO + 5, 1, 32'h0, obs);
    checks++;
    if (obs != 1) begin
      errors++;
      $display("FAIL timeout_master: got %0d want 1", obs);
    end
    arm(0, 0, 1, 32'h0000_0200, 32'h5555_AAAA, 4'b1000);
    serve(TO + 5, 0, 32'h0, obs);
    arm(1, 1, 0, 32'h0000_0300, 32'h0, 4'h0);
    serve(TO - 1, 0, 32'hCAFE_F00D, obs);
  endtask

  task automatic test_reset_mid_busy();
    int obs;
    arm(0, 1, 0, 32'h0000_0400, 32'h0, 4'h0);
    serve(1, 0, 32'h0BAD_F00D, obs);
    arm(1, 1, 0, 32'h0000_0500, 32'h0, 4'h0);
    drive_masters();
    tick();
    tick(); tick();
    checks++;
    if (s_read_request !== 1'b1 || s_address !== 32'h0000_0500) begin
      errors++;
      $display("FAIL mid_busy_grant: got rd=%b a=%h want 1 00000500", s_read_request, s_address);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({s_read_request, s_write_request} !== 2'b00) begin
      errors++;
      $display("FAIL reset_async_drop: got rd/wr=%b%b want 00", s_read_request, s_write_request);
    end
    s_read_response = 1'b1;
    s_read_data = 32'h7777_7777;
    #1;
    checks++;
    if ({m_read_response, m_write_response, m_error, m_read_data} !== '0) begin
      errors++;
      $display("FAIL reset_no_pulse: got rr=%b wr=%b err=%b d=%h want zero",
               m_read_response, m_write_response, m_error, m_read_data);
    end
    tick();
    s_read_response = 1'b0;
    reset = 1'b0;
    ptr = 0;
    arm(0, 0, 1, 32'h0000_0600, 32'h1357_9BDF, 4'b0101);
    serve(2, 0, 32'h0, obs);
    checks++;
    if (obs != 0) begin
      errors++;
      $display("FAIL reset_priority: got %0d want 0", obs);
    end
    serve(0, 0, 32'h2468_ACE0, obs);
  endtask

  task automatic test_random();
    int obs, r, rc;
    bit any;
    for (int t = 0; t < 40; t++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (!want_rd[i] && !want_wr[i] && $urandom_range(0, 1) == 1) arm_random(i);
        if (want_rd[i] || want_wr[i]) any = 1;
      end
      if (!any) arm_random($urandom_range(0, N - 1));
      r  = $urandom_range(0, 9);
      rc = (r < 8) ? $urandom_range(0, 4) : ((r == 8) ? TO - 1 : TO + 3);
      serve(rc, 1, $urandom, obs);
      checks++;
      if (obs < 0) begin
        errors++;
        $display("FAIL random_no_response t=%0d: got no pulse want one", t);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) arm(i, 0, 0, '0, '0, '0);
    test_reset();
    test_contention();
    test_single_read();
    test_fairness();
    test_read_write_same_master();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
